// File: rtl/ram32x4_arbiter.sv
// Round-robin arbiter sharing one 32x4 single-port RAM between two requesters,
// with a full-memory clear sweep that takes priority over pending accesses.
module ram32x4_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [4:0] addr_a,
  input  logic [4:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       done_a,
  output logic       done_b,
  output logic [3:0] rdata_a,
  output logic [3:0] rdata_b,
  input  logic       clear_req,
  output logic       busy,
  output logic       clear_done,
  output logic [4:0] mem_addr,
  output logic [3:0] mem_data,
  output logic       mem_wren,
  input  logic [3:0] mem_q
);

  localparam int unsigned AW        = 5;
  localparam int unsigned DW        = 4;
  localparam int unsigned LAST_ADDR = 31;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, CLEAR} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t        state, next_state;
  logic          last_b;      // 1 = B holds the current/most recent grant
  logic          cap_we;
  logic          clear_pend;
  logic [AW-1:0] cnt;
  logic          sel_b;
  req_t          sel;

  logic          busy_n, done_a_n, done_b_n, clear_done_n, mem_wren_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_data_n;

  // Round-robin pick: on a tie the side not granted last wins
  always_comb begin
    sel_b = req_b & (~req_a | ~last_b);
    sel   = sel_b ? {we_b, addr_b, wdata_b} : {we_a, addr_a, wdata_a};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (clear_req || clear_pend) next_state = CLEAR;
        else if (req_a || req_b)     next_state = ACCESS;
      end
      ACCESS:  next_state = WAIT;
      WAIT:    next_state = DONE;
      DONE:    next_state = IDLE;
      CLEAR:   if (cnt == AW'(LAST_ADDR)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the upcoming state
  always_comb begin
    busy_n       = 1'b0;
    done_a_n     = 1'b0;
    done_b_n     = 1'b0;
    clear_done_n = 1'b0;
    mem_wren_n   = 1'b0;
    mem_addr_n   = '0;
    mem_data_n   = '0;
    busy_n = (next_state != IDLE);
    case (next_state)
      ACCESS: begin
        mem_addr_n = sel.addr;
        mem_data_n = sel.wdata;
        mem_wren_n = sel.we;
      end
      CLEAR: begin
        mem_addr_n = (state == CLEAR) ? cnt + AW'(1) : '0;
        mem_wren_n = 1'b1;
      end
      DONE: begin
        done_a_n = ~last_b;
        done_b_n = last_b;
      end
      IDLE:    clear_done_n = (state == CLEAR);
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_b     <= 1'b1;
      cap_we     <= 1'b0;
      clear_pend <= 1'b0;
      cnt        <= '0;
      rdata_a    <= '0;
      rdata_b    <= '0;
      busy       <= 1'b0;
      done_a     <= 1'b0;
      done_b     <= 1'b0;
      clear_done <= 1'b0;
      mem_wren   <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      busy       <= busy_n;
      done_a     <= done_a_n;
      done_b     <= done_b_n;
      clear_done <= clear_done_n;
      mem_wren   <= mem_wren_n;
      mem_addr   <= mem_addr_n;
      mem_data   <= mem_data_n;

      if (state == IDLE && next_state == ACCESS) begin
        cap_we <= sel.we;
        last_b <= sel_b;
      end

      // Clears requested while busy collapse into a single pending sweep
      if (state == IDLE && next_state == CLEAR) begin
        clear_pend <= 1'b0;
        cnt        <= '0;
      end else if (state != IDLE && clear_req) begin
        clear_pend <= 1'b1;
      end

      if (state == CLEAR) cnt <= cnt + AW'(1);

      if (state == WAIT && !cap_we) begin
        if (last_b) rdata_b <= mem_q;
        else        rdata_a <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Directed bench for ram32x4_arbiter with a behavioural 32x4 registered RAM.
module tb_ram32x4_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [4:0] addr_a = '0, addr_b = '0;
  logic [3:0] wdata_a = '0, wdata_b = '0;
  logic       done_a, done_b, busy, clear_done, mem_wren;
  logic [3:0] rdata_a, rdata_b, mem_data, mem_q;
  logic [4:0] mem_addr;
  logic       clear_req = 1'b0;
  logic [3:0] ram [32];
  logic [21:0] outs;

  int errors = 0;
  int checks = 0;

  ram32x4_arbiter dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .done_a(done_a), .done_b(done_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  assign outs = {busy, done_a, done_b, clear_done, mem_wren, mem_addr, mem_data, rdata_a, rdata_b};

  // RAM model: registered address/data/wren, q valid the cycle after
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= 4'(i);
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_data;
    end
    mem_q <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One transaction from IDLE; returns what was seen in the DONE cycle
  task automatic xact(input logic side_b, input logic we, input logic [4:0] addr,
                      input logic [3:0] data, output logic [1:0] dn,
                      output logic [3:0] ra, output logic [3:0] rb);
    if (side_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = data; end
    else        begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = data; end
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    dn = {done_a, done_b};
    ra = rdata_a;
    rb = rdata_b;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (outs !== 22'h0) begin errors++; $display("FAIL reset_outs got=%h want=0", outs); end
    reset = 1'b0;
    tick();
    checks++; if ({busy, mem_wren} !== 2'b00) begin errors++; $display("FAIL reset_idle got=%b want=00", {busy, mem_wren}); end
  endtask

  task automatic test_write_read();
    logic [1:0] dn;
    logic [3:0] ra, rb;
    req_a = 1'b1; we_a = 1'b1; addr_a = 5'd5; wdata_a = 4'hA;
    tick();
    checks++; if ({mem_wren, mem_addr, mem_data, busy} !== {1'b1, 5'd5, 4'hA, 1'b1})
      begin errors++; $display("FAIL wr_access got=%b want=%b", {mem_wren, mem_addr, mem_data, busy}, {1'b1, 5'd5, 4'hA, 1'b1}); end
    req_a = 1'b0; we_a = 1'b0; addr_a = 5'd7; wdata_a = 4'h3;
    tick();
    checks++; if ({mem_wren, busy} !== 2'b01) begin errors++; $display("FAIL wr_wait got=%b want=01", {mem_wren, busy}); end
    tick();
    checks++; if ({done_a, done_b} !== 2'b10) begin errors++; $display("FAIL wr_done got=%b want=10", {done_a, done_b}); end
    checks++; if (rdata_a !== 4'h0) begin errors++; $display("FAIL wr_rdata got=%h want=0", rdata_a); end
    tick();
    checks++; if ({done_a, busy} !== 2'b00) begin errors++; $display("FAIL wr_idle got=%b want=00", {done_a, busy}); end
    xact(1'b0, 1'b0, 5'd5, 4'h0, dn, ra, rb);
    checks++; if (dn !== 2'b10) begin errors++; $display("FAIL rd_done got=%b want=10", dn); end
    checks++; if (ra !== 4'hA) begin errors++; $display("FAIL rd_data got=%h want=a", ra); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_dn;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd5;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'd6;
    for (int t = 1; t <= 15; t++) begin
      tick();
      exp_dn = (t % 8 == 3) ? 2'b10 : (t % 8 == 7) ? 2'b01 : 2'b00;
      checks++; if ({done_a, done_b} !== exp_dn) begin errors++; $display("FAIL rr_done t=%0d got=%b want=%b", t, {done_a, done_b}, exp_dn); end
      if (t % 4 == 1) begin
        checks++; if (mem_addr !== ((t % 8 == 1) ? 5'd5 : 5'd6))
          begin errors++; $display("FAIL rr_grant t=%0d got=%0d want=%0d", t, mem_addr, (t % 8 == 1) ? 5 : 6); end
      end
      if (t == 3 || t == 7) begin
        checks++; if ({rdata_a, rdata_b} !== ((t == 3) ? 8'h50 : 8'h56))
          begin errors++; $display("FAIL rr_rdata t=%0d got=%h want=%h", t, {rdata_a, rdata_b}, (t == 3) ? 8'h50 : 8'h56); end
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_clear();
    logic [1:0] dn;
    logic [3:0] ra, rb;
    int seen = 0;
    for (int a = 0; a < 32; a++) begin
      xact(1'b0, 1'b1, 5'(a), 4'hF, dn, ra, rb);
      if (dn == 2'b10) seen++;
    end
    checks++; if (seen != 32) begin errors++; $display("FAIL fill_done got=%0d want=32", seen); end
    checks++; if (rdata_a !== 4'h5) begin errors++; $display("FAIL fill_rdata got=%h want=5", rdata_a); end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++; if ({busy, mem_wren, mem_addr, mem_data, clear_done} !== {1'b1, 1'b1, 5'(k), 4'h0, 1'b0})
        begin errors++; $display("FAIL clr_sweep k=%0d got=%b want=%b", k, {busy, mem_wren, mem_addr, mem_data, clear_done}, {1'b1, 1'b1, 5'(k), 4'h0, 1'b0}); end
      tick();
    end
    checks++; if ({busy, mem_wren, clear_done} !== 3'b001) begin errors++; $display("FAIL clr_end got=%b want=001", {busy, mem_wren, clear_done}); end
    tick();
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL clr_pulse got=%b want=0", clear_done); end
    xact(1'b0, 1'b0, 5'd0, 4'h0, dn, ra, rb);
    checks++; if ({dn, ra} !== {2'b10, 4'h0}) begin errors++; $display("FAIL clr_rd0 got=%b want=100000", {dn, ra}); end
    xact(1'b1, 1'b0, 5'd31, 4'h0, dn, ra, rb);
    checks++; if ({dn, rb} !== {2'b01, 4'h0}) begin errors++; $display("FAIL clr_rd31 got=%b want=010000", {dn, rb}); end
  endtask

  task automatic test_clear_during_wait();
    int n = 0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 5'd3; wdata_b = 4'h7;
    tick();
    req_b = 1'b0;
    clear_req = 1'b1;
    tick();
    tick();
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL cw_done_b got=%b want=1", done_b); end
    clear_req = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'd3;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cw_idle got=%b want=0", busy); end
    tick();
    checks++; if ({busy, mem_wren, mem_addr} !== {1'b1, 1'b1, 5'd0})
      begin errors++; $display("FAIL cw_clear_start got=%b want=1100000", {busy, mem_wren, mem_addr}); end
    while (clear_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL cw_clear_len got=%0d want=32", n); end
    tick();
    checks++; if ({busy, mem_wren, mem_addr} !== {1'b1, 1'b0, 5'd3})
      begin errors++; $display("FAIL cw_a_access got=%b want=1000011", {busy, mem_wren, mem_addr}); end
    req_a = 1'b0;
    tick();
    tick();
    checks++; if ({done_a, rdata_a} !== {1'b1, 4'h0}) begin errors++; $display("FAIL cw_a_done got=%b want=10000", {done_a, rdata_a}); end
    tick();
  endtask

  task automatic test_reset_during_clear();
    logic [2:0] any = 3'b000;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    checks++; if (mem_addr !== 5'd10) begin errors++; $display("FAIL rc_counter got=%0d want=10", mem_addr); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (outs !== 22'h0) begin errors++; $display("FAIL rc_async got=%h want=0", outs); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      any = any | {busy, mem_wren, clear_done};
    end
    checks++; if (any !== 3'b000) begin errors++; $display("FAIL rc_after got=%b want=000", any); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_clear();
    test_clear_during_wait();
    test_reset_during_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram32x4_arbiter.md
RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req_a, req_b  input  1 each  access requests.
REQ-004 SHALL have ports: we_a, we_b  input  1 each  1 = write, 0 = read.
REQ-005 SHALL have ports: addr_a, addr_b  input  5 each  word address.
REQ-006 SHALL have ports: wdata_a, wdata_b  input  4 each  write data.
REQ-007 SHALL have ports: done_a, done_b  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have ports: rdata_a, rdata_b  output  4 each  registered read data.
REQ-009 SHALL have port: clear_req  input  1  request to zero all 32 words.
REQ-010 SHALL have ports: busy  output  1  high when not IDLE; clear_done  output  1  one-cycle pulse at end of clear.
REQ-011 SHALL have ports: mem_addr  output  5; mem_data  output  4; mem_wren  output  1; mem_q  input  4: shared 32x4 single-port RAM. The RAM registers address, data and wren on clock; mem_q is valid the cycle after the sampling edge.

Function
REQ-012 SHALL implement states IDLE, ACCESS, WAIT, DONE, CLEAR.
REQ-013 IDLE: pending clear (clear_req, or latched clear flag) SHALL have top priority -> CLEAR; else any req -> ACCESS with grant; else stay.
REQ-014 Arbitration SHALL be round-robin: both req high -> grant the requester not granted last; one high -> grant it; last_grant SHALL reset to B so A wins the first tie.
REQ-015 On the IDLE->ACCESS edge, the granted requester's we/addr/wdata SHALL be captured into internal registers; later input changes SHALL not affect the transaction.
REQ-016 ACCESS: mem_addr/mem_data SHALL equal the captured values; mem_wren SHALL equal the captured we; next state WAIT.
REQ-017 WAIT: mem_wren SHALL be 0; on a read, mem_q SHALL be loaded into the granted requester's rdata at the end of this cycle; next state DONE.
REQ-018 DONE: the granted requester's done SHALL be high for exactly this cycle; the other requester's rdata SHALL be unchanged; next state IDLE.
REQ-019 Latency: req sampled high in IDLE at edge n -> done pulse in cycle n+3; minimum 4 cycles per transaction, including back-to-back with req held high.
REQ-020 Writes SHALL take the same path and latency as reads; rdata SHALL not change on writes.
REQ-021 A requester SHALL hold req high until its done; dropping req mid-transaction SHALL not abort it (done still pulses).
REQ-022 clear_req high in any non-IDLE state SHALL set a clear-pending flag, serviced at the next IDLE; multiple requests while pending SHALL merge into one clear.
REQ-023 CLEAR: a 5-bit counter SHALL start at 0; each cycle mem_addr = counter, mem_data = 4'h0, mem_wren = 1; the counter SHALL increment; after address 31 is written (32 cycles) -> IDLE with clear_done high for one cycle on that transition; the pending flag SHALL be cleared on entry to CLEAR.
REQ-024 Requests arriving during CLEAR SHALL wait; arbitration SHALL resume in the IDLE after clear, with last_grant unchanged.
REQ-025 busy SHALL be 0 in IDLE and 1 in all other states.
REQ-026 mem_wren SHALL be 1 only in ACCESS with a captured write, or in CLEAR.

Reset
REQ-027 reset high SHALL immediately force IDLE, last_grant = B, clear-pending = 0, counter = 0, captured registers = 0, and all outputs (done_*, rdata_*, mem_*, busy, clear_done) = 0, even mid-transaction or mid-clear; no done pulse for the aborted transaction.

Verification
REQ-028 Write A addr 5 data 4'hA, then read A addr 5 -> mem_wren high one cycle; done_a at n+3 each time; rdata_a = 4'hA.
REQ-029 req_a and req_b high together from reset, both held -> grant order A, B, A, B; done pulses 4 cycles apart; rdata of the non-granted side unchanged.
REQ-030 Write all 32 addresses to 4'hF, pulse clear_req -> busy for 32 CLEAR cycles with mem_addr 0..31 and mem_wren = 1; clear_done pulses once; reads of addr 0 and 31 return 4'h0.
REQ-031 clear_req pulsed during B's WAIT state -> done_b still pulses; CLEAR starts in the following IDLE; a req_a pending during clear is served after clear_done.
REQ-032 reset asserted asynchronously during CLEAR at counter 10 -> all outputs 0 at once; no clear_done; after release with no requests, busy = 0 and mem_wren = 0.
